// File: rtl/univib_pkg.sv
// Shared types for the time-shared one-shot pulse scheduler.
// State encoding and a width helper for the tick counter.
package univib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic int max_w(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: first active request at or above ptr, with wrap.
// Purely combinational; win is one-hot, valid flags any request.
module rr_arb #(
  parameter int REQS = 4
) (
  input  logic [REQS-1:0]         req,
  input  logic [$clog2(REQS)-1:0] ptr,
  output logic [REQS-1:0]         win,
  output logic                    valid
);

  localparam int PW = $clog2(REQS);

  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int k = 0; k < REQS; k++) begin
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
      idx = (idx == PW'(REQS - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/univib_sched.sv
// Shared non-retriggerable one-shot, granted round-robin to REQS users.
// Each pulse runs to completion, then GAP low ticks before next grant.
module univib_sched
  import univib_pkg::*;
#(
  parameter int REQS = 4,
  parameter int LW   = 4,
  parameter int GAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQS-1:0]   req,
  input  logic [REQS*LW-1:0] len,
  output logic [REQS-1:0]   gnt,
  output logic [REQS-1:0]   done,
  output logic              q,
  output logic              q_,
  output logic              busy
);

  localparam int PW = $clog2(REQS);
  localparam int CW = max_w(LW, $clog2(GAP + 1));

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [REQS-1:0] win;
  logic            valid;
  logic [LW-1:0]   wlen;
  logic [PW-1:0]   nptr;

  rr_arb #(
    .REQS(REQS)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .win  (win),
    .valid(valid)
  );

  // Winner's length field and the pointer slot just past it.
  always_comb begin
    wlen = '0;
    nptr = '0;
    for (int i = 0; i < REQS; i++) begin
      if (win[i]) begin
        wlen = len[i*LW +: LW];
        nptr = (i == REQS - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  assign q_ = ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      done  <= '0;
      q     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= '0;
      unique case (state)
        ST_IDLE: begin
          if (valid) begin
            state <= ST_PULSE;
            gnt   <= win;
            q     <= 1'b1;
            busy  <= 1'b1;
            ptr   <= nptr;
            // Zero length behaves as a single tick.
            cnt   <= (wlen == '0) ? '0 : CW'(wlen - 1'b1);
          end
        end
        ST_PULSE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            q    <= 1'b0;
            gnt  <= '0;
            done <= gnt;
            if (GAP > 0) begin
              state <= ST_GAP;
              cnt   <= CW'(GAP - 1);
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/univib_sched.md
Name: univib_sched

Overview:
- Shared one-shot timing pulse generator: a single retriggerable-free monostable time-shared between REQS requesters.
- Each requester asks for one timing pulse of its own programmed length in clk ticks.
- Requests are arbitrated round-robin; each pulse runs to completion, then a fixed recovery gap follows.
- Sits between the timing-chain requesters (memory cycle, bus timeouts, console strobes) and the logic that consumes the shared pulse.

Parameters:
- REQS, 4, number of requesters (2..8).
- LW, 4, width of each per-requester length field in ticks.
- GAP, 1, recovery ticks with q low after every pulse (0..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  REQS  level request per requester; held until its done
- len  input  REQS*LW  pulse length per requester; field i = len[i*LW +: LW]
- gnt  output  REQS  one-hot owner of the current pulse; 0 when not in PULSE
- done  output  REQS  one-hot, single-cycle, marks end of the owner's pulse
- q  output  1  shared pulse, registered
- q_  output  1  ~q
- busy  output  1  high in PULSE or GAP

Behaviour:
- One clock and one reset. Reset is synchronous and active-high: ports clk and rst.
- Reset values: q=0, q_=1, gnt=0, done=0, busy=0, state=IDLE, rr pointer=0, counter=0.
- The FSM has three states: IDLE, PULSE, GAP.
- IDLE:
  - Arbitration is combinational on req, starting at the rr pointer and searching upward with wrap.
  - If any req is high, the next edge sets state=PULSE, gnt=onehot(winner), q=1, and counter=len[winner]-1.
  - The rr pointer is set to (winner+1) mod REQS.
  - If no req is high, the block stays in IDLE.
- Length rules:
  - len is sampled only at grant. Later changes to len have no effect on a running pulse.
  - len=0 is treated as 1.
  - q is high for exactly max(len,1) consecutive cycles.
- PULSE:
  - While counter!=0, counter decrements each cycle.
  - When counter==0, the next edge sets q=0, gnt=0, and done=previous gnt for one cycle.
  - The next state is GAP with counter=GAP-1 if GAP>0, otherwise IDLE.
- GAP: counter decrements each cycle. When counter==0, the next edge goes to IDLE.
- done is registered. It is asserted in the first cycle after q falls.
- The requester must drop req in the cycle done is seen, or it competes again.
- Non-abortable:
  - Deasserting req during PULSE does not shorten the pulse, and done is still issued.
  - A req arriving during PULSE or GAP waits.
- Rising edges of q are separated by at least max(len,1)+GAP+1 cycles, because IDLE always lasts at least one cycle.
- Fairness: a requester holding req continuously is granted at most once per REQS grants when others are requesting.
- A lone requester is regranted after gap+IDLE.
- Simultaneous requests in the same cycle are resolved purely by the rr pointer.
- Reset mid-PULSE or mid-GAP: at the next edge all outputs return to reset values. No done is issued for the aborted pulse.
- The counter is LW bits wide, or $clog2(GAP+1) bits if that is larger. There is no wrap, because the counter is only decremented when nonzero.

Decomposition:
- Shared package univib_pkg holds:
  - the state enum (IDLE, PULSE, GAP) as 2-bit constants;
  - a max-width helper function for the counter width.
- Sub-module rr_arb(REQS):
  - inputs req and ptr;
  - outputs one-hot win and valid;
  - combinational.
- The FSM, counter and pointer stay in univib_sched.

Test Plan:
- Reset then single req[0]=1 with len0=3, GAP=1:
  - q high 3 cycles starting the cycle after req is sampled;
  - done[0] pulses 1 cycle after q falls;
  - busy drops after the gap;
  - gnt=0001 during q.
- req=1111 held together, all len=2, GAP=1:
  - grants in order 0,1,2,3,0;
  - q rising edges every 4 cycles;
  - exactly one done bit per pulse.
- len1=0, req[1] only: q high exactly 1 cycle, done[1]=1 next cycle.
- req[2] dropped mid-pulse (len2=5): q still high 5 cycles and done[2] still issued. Also change len2 to 1 during the pulse: length unchanged.
- rst asserted in the 2nd cycle of a 6-tick pulse: next cycle q=0, gnt=0, busy=0, no done. Next grant starts from requester 0.
- GAP=0 build, req[0]=1 held, len0=2: q pattern 1,1,0,1,1,0 (one IDLE cycle between pulses).
